// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator with sub-word read-modify-write
//
// Accepts one RV32 load/store at a time, issues it to a word-addressed memory
// and returns extended load data (or a store completion / error) on a
// valid/ready response channel. Sub-word stores are done as read-modify-write
// because the memory only has a whole-word write strobe.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_funct3       1 = store; RISC-V width/sign encoding
//   req_addr, req_wdata      byte address; right-aligned store data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       extended load data (0 for stores/errors); error flag
//   mem_addr, mem_wd, mem_we word index, write data, write strobe
//   mem_rd                   combinational read data for mem_addr
module lsu_mem_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] merged_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  req_illegal;
    logic                  is_sw;
    logic                  we_raw;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merge_data;

    // Address bits above the memory index are deliberately ignored (silent wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    // Legality is decided on the raw request so an illegal access never
    // reaches the memory port.
    always_comb begin
        req_illegal = 1'b0;
        case (req_funct3)
            3'b000: req_illegal = 1'b0;
            3'b001: req_illegal = req_addr[0];
            3'b010: req_illegal = (req_addr[1:0] != 2'b00);
            3'b100: req_illegal = req_we;
            3'b101: req_illegal = req_we || req_addr[0];
            default: req_illegal = 1'b1;
        endcase
    end

    assign is_sw = we_q && (f3_q == 3'b010);

    // Lane extraction for loads.
    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'd0: byte_sel = mem_rd[7:0];
            2'd1: byte_sel = mem_rd[15:8];
            2'd2: byte_sel = mem_rd[23:16];
            default: byte_sel = mem_rd[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    end

    always_comb begin
        load_data = '0;
        case (f3_q)
            3'b000: load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001: load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b010: load_data = mem_rd;
            3'b100: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101: load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_data = '0;
        endcase
    end

    // Sub-word store merge: the current word with one lane replaced.
    always_comb begin
        merge_data = mem_rd;
        if (f3_q == 3'b000) begin
            case (addr_q[1:0])
                2'd0: merge_data[7:0]   = wdata_q[7:0];
                2'd1: merge_data[15:8]  = wdata_q[7:0];
                2'd2: merge_data[23:16] = wdata_q[7:0];
                default: merge_data[31:24] = wdata_q[7:0];
            endcase
        end else if (f3_q == 3'b001) begin
            if (addr_q[1]) begin
                merge_data[31:16] = wdata_q[15:0];
            end else begin
                merge_data[15:0] = wdata_q[15:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = req_illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (we_q && !is_sw) begin
                    state_nx = WRITE;
                end else begin
                    state_nx = RESP;
                end
            end
            WRITE: state_nx = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr[ADDR_WIDTH+1:0];
                        wdata_q <= req_wdata;
                        err_q   <= req_illegal;
                        rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_data;
                    end else begin
                        merged_q <= merge_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Write strobe is gated by reset so a reset landing in a write cycle
    // cannot corrupt memory.
    assign we_raw    = ((state == ACCESS) && is_sw) || (state == WRITE);
    assign mem_we    = we_raw && !rst;
    assign mem_wd    = mem_we ? ((state == WRITE) ? merged_q : wdata_q) : '0;
    assign mem_addr  = addr_q[ADDR_WIDTH+1:2];
    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - scoreboard bench for lsu_mem_master
module tb_lsu_mem_master;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;
    logic          mem_we;
    logic [31:0]   mem_rd;

    lsu_mem_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<AW)-1];
    assign mem_rd = mem[mem_addr];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_count = 0;
    int wr_edge = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          pend_we = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [31:0]   pend_wd = '0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];
    bit seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: write-port values are captured mid-low-phase and
    // committed at the following rising edge.
    always @(negedge clk) begin
        #2;
        pend_we   = mem_we;
        pend_addr = mem_addr;
        pend_wd   = mem_wd;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (pend_we) begin
            mem[pend_addr] = pend_wd;
            wr_count++;
            wr_edge = cyc;
            wr_addr = pend_addr;
            wr_data = pend_wd;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        #1;
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rdata %h err %0d expected no response", rsp_rdata, rsp_err);
            end else begin
                if (!seen) begin
                    chk("rsp_latency", cyc - sb[0].acc, sb[0].lat);
                    seen = 1;
                end
                chk("rsp_rdata", rsp_rdata, sb[0].rd);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, sb[0].err});
                chk("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input bit push, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        acc = cyc + 1;
        if (push) sb.push_back('{exp_rd, exp_err, lat, acc});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !req_ready) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got pending %0d expected 0", sb.size());
        end
    endtask

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, output int acc);
        issue(we, f3, addr, wd, exp_rd, exp_err, lat, 1'b1, acc);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int w0;
        int n;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[2] = 32'h11223344;
        mem[3] = 32'h8899AABB;
        mem[4] = 32'h55667788;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_mem_addr", {27'b0, mem_addr}, 32'd0);
        rst = 1'b0;

        // Loads from word 3 = 0x8899AABB
        do_op(1'b0, 3'b000, 32'h0E, 32'h0, 32'hFFFFFF99, 1'b0, 1, acc);
        do_op(1'b0, 3'b100, 32'h0E, 32'h0, 32'h00000099, 1'b0, 1, acc);
        do_op(1'b0, 3'b001, 32'h0E, 32'h0, 32'hFFFF8899, 1'b0, 1, acc);
        do_op(1'b0, 3'b101, 32'h0C, 32'h0, 32'h0000AABB, 1'b0, 1, acc);
        do_op(1'b0, 3'b010, 32'h0C, 32'h0, 32'h8899AABB, 1'b0, 1, acc);

        // SH into upper half of word 2
        w0 = wr_count;
        do_op(1'b1, 3'b001, 32'h0A, 32'h1234CAFE, 32'h0, 1'b0, 2, acc);
        chk("sh_write_count", wr_count - w0, 32'd1);
        chk("sh_write_edge", wr_edge - acc, 32'd2);
        chk("sh_write_addr", {27'b0, wr_addr}, 32'd2);
        chk("sh_write_data", wr_data, 32'hCAFE3344);
        do_op(1'b0, 3'b010, 32'h08, 32'h0, 32'hCAFE3344, 1'b0, 1, acc);

        // SB into byte 1 of word 1
        do_op(1'b1, 3'b000, 32'h05, 32'h00000077, 32'h0, 1'b0, 2, acc);
        do_op(1'b0, 3'b100, 32'h05, 32'h0, 32'h00000077, 1'b0, 1, acc);
        do_op(1'b0, 3'b010, 32'h04, 32'h0, 32'h00007700, 1'b0, 1, acc);

        // SW at the top of memory and an address that wraps to word 0
        w0 = wr_count;
        do_op(1'b1, 3'b010, 32'h7C, 32'hDEADBEEF, 32'h0, 1'b0, 1, acc);
        chk("sw_write_count", wr_count - w0, 32'd1);
        chk("sw_write_edge", wr_edge - acc, 32'd1);
        chk("sw_write_addr", {27'b0, wr_addr}, 32'd31);
        chk("sw_mem31", mem[31], 32'hDEADBEEF);
        do_op(1'b1, 3'b010, 32'h80, 32'h0BADF00D, 32'h0, 1'b0, 1, acc);
        chk("sw_wrap_addr", {27'b0, wr_addr}, 32'd0);
        chk("sw_wrap_mem0", mem[0], 32'h0BADF00D);

        // Illegal requests
        w0 = wr_count;
        do_op(1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 1'b1, 0, acc);
        do_op(1'b1, 3'b001, 32'h03, 32'hFFFF, 32'h0, 1'b1, 0, acc);
        do_op(1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 0, acc);
        do_op(1'b1, 3'b100, 32'h00, 32'hFF, 32'h0, 1'b1, 0, acc);
        chk("err_no_write", wr_count - w0, 32'd0);
        chk("err_mem0_kept", mem[0], 32'h0BADF00D);

        // Response held off for 5 cycles
        rsp_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h0C, 32'h0, 32'h8899AABB, 1'b0, 1, 1'b1, acc);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_rsp_arrived", {31'b0, rsp_valid}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("resume_req_ready", {31'b0, req_ready}, 32'd1);
        wait_done();

        // Reset during the WRITE cycle of an SB
        w0 = wr_count;
        issue(1'b1, 3'b000, 32'h10, 32'h000000AB, 32'h0, 1'b0, 2, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_write_mem_we", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_no_write", wr_count - w0, 32'd0);
        chk("rst_mem4_kept", mem[4], 32'h55667788);
        do_op(1'b0, 3'b010, 32'h10, 32'h0, 32'h55667788, 1'b0, 1, acc);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that sits between the core's memory stage and the word-addressed data memory. It accepts one RISC-V load or store request at a time over a valid/ready handshake and converts the byte address to a word index. It performs sub-word stores as a read-modify-write, because the memory only has a whole-word write enable. It returns sign- or zero-extended load data, or a completion, over a valid/ready response channel.

## Interface
- ADDR_WIDTH, 5, memory word-index width (memory holds 2**ADDR_WIDTH words)
- DATA_WIDTH, 32, word width; fixed at 32 for RV32 byte-lane logic
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned access or illegal funct3
- mem_addr  out  ADDR_WIDTH  word index = latched addr[ADDR_WIDTH+1:2]
- mem_wd  out  32  write data; 0 when mem_we = 0
- mem_we  out  1  write strobe; the memory writes at posedge
- mem_rd  in  32  combinational read data for mem_addr

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid: latch we, funct3, addr and wdata; go to ACCESS.
  - If the request is illegal, go directly to RESP with rsp_err = 1 and rsp_rdata = 0; no memory cycle is issued.
- Illegal requests:
  - funct3 not in {000, 001, 010, 100, 101}.
  - Store with funct3 100 or 101.
  - Halfword with addr[0] != 0.
  - Word with addr[1:0] != 0.
- Address upper bits: addr bits above ADDR_WIDTH+1 are ignored, so addresses wrap silently with no error.
- ACCESS for a load:
  - mem_addr is driven and mem_rd is sampled.
  - Lane is selected by addr[1:0] (byte) or addr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Result is registered into rsp_rdata; go to RESP.
- ACCESS for SW: mem_we = 1 and mem_wd = wdata; go to RESP.
- ACCESS for SB/SH:
  - Sample mem_rd and register merged = mem_rd with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - Go to WRITE.
- WRITE: mem_we = 1, mem_wd = merged; go to RESP.
- RESP
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready, go to IDLE.
  - req_ready = 0 in every non-IDLE state.
- mem_we is asserted only in ACCESS (SW) or WRITE. mem_addr holds the latched index at all times.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_err 0, rsp_rdata 0, mem_we 0, mem_wd 0, mem_addr 0, req_ready 0.
- req_ready and mem_we are gated by !rst combinationally.
- Latency, with request accepted at edge N:
  - Load / SW: rsp_valid is high from cycle N+2, i.e. after edge N+1. The SW memory write occurs at edge N+1.
  - SB/SH: rsp_valid is high from cycle N+3. The write occurs at edge N+2.
  - Illegal request: rsp_valid is high from cycle N+1.
- Response handshake completes at the first edge where rsp_valid and rsp_ready are both high. req_ready returns in the following cycle.
- Minimum spacing between accepted requests: 3 cycles (load/SW), 4 cycles (SB/SH), 2 cycles (error).
- rsp_ready held low: the block stays in RESP indefinitely and outputs do not change.
- Reset mid-operation:
  - The block returns to IDLE at the reset edge and any pending response is dropped.
  - If rst is high during WRITE, or during ACCESS for SW, mem_we is 0 in that cycle, so no write occurs.
- Read-modify-write atomicity: nothing else drives the memory port during ACCESS→WRITE, so the merge is atomic.

## Test plan
- Memory word 3 = 0x8899AABB. LB addr 0x0E, then LBU addr 0x0E, each with rsp_ready = 1 → rsp_rdata 0xFFFFFF99 then 0x00000099. rsp_valid is high 2 cycles after each acceptance.
- SH addr 0x0A with wdata 0x1234CAFE, word 2 initially 0x11223344 → mem_we pulses exactly once, in cycle N+2, with mem_addr 2 and mem_wd 0xCAFE3344. A following LW addr 0x08 returns 0xCAFE3344.
- SW addr 0x7C with data 0xDEADBEEF and ADDR_WIDTH 5 → write to word 31. SW addr 0x80 wraps to word 0.
- LW addr 0x06, SH addr 0x03, and a load with funct3 011 → rsp_err = 1 with rsp_rdata 0 one cycle after acceptance; mem_we never asserts.
- Load response held with rsp_ready = 0 for 5 cycles → rsp_valid, rsp_rdata and req_ready = 0 all stable throughout. Acceptance resumes the cycle after rsp_ready = 1.
- SB issued, then rst asserted in its WRITE cycle → mem_we stays 0 and memory is unchanged. After reset, req_ready = 1 and rsp_valid = 0.
